// File: rtl/muldiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit: operation codes
// and the controller state encoding.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: shift-add multiply step or restoring
// trial-subtract divide step, chosen by mode_div. Purely combinational.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] part_hi,
  input  logic [WIDTH-1:0] part_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] shifted_lo;
  logic             fits;

  // NOTE: every output of this block is assigned on every path, so no latch
  // can be inferred; keep it that way when adding branches.
  always_comb begin
    sum        = {1'b0, part_hi} + ({1'b0, operand} & {(WIDTH+1){part_lo[0]}});
    shifted_lo = {part_hi[WIDTH-2:0], part_lo[WIDTH-1]};
    // The partial remainder always stays below the divisor, so a successful
    // trial difference fits in WIDTH bits and the modular subtract is exact.
    fits       = {part_hi, part_lo[WIDTH-1]} >= {1'b0, operand};
    if (mode_div) begin
      next_hi = fits ? (shifted_lo - operand) : shifted_lo;
      next_lo = {part_lo[WIDTH-2:0], fits};
    end else begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], part_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies sign fix-up in FIX.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_t           op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] part_hi_q, part_hi_d;
  logic [WIDTH-1:0] part_lo_q, part_lo_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_div;
  logic             signed_op;
  logic             a_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_div = (op_q == DIV) || (op_q == DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (is_div),
    .part_hi  (part_hi_q),
    .part_lo  (part_lo_q),
    .operand  (mcand_q),
    .next_hi  (step_hi),
    .next_lo  (step_lo)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered handshake outputs.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  // Operand magnitudes and result signs captured at start.
  always_comb begin
    signed_op = (op == MULT) || (op == DIV);
    a_neg     = signed_op && a[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  // Sign fix-up; most-negative / -1 falls out naturally as a wrapped negate.
  always_comb begin
    prod_fix = neg_q ? -{part_hi_q, part_lo_q} : {part_hi_q, part_lo_q};
    quo_fix  = div0_q ? '1 : (neg_q ? -part_lo_q : part_lo_q);
    rem_fix  = neg_rem_q ? -part_hi_q : part_hi_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    part_hi_d = part_hi_q;
    part_lo_d = part_lo_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          mcand_d   = b_mag;
          part_hi_d = '0;
          part_lo_d = a_mag;
          neg_d     = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = a_neg;
          div0_d    = (b == '0);
          cnt_d     = '0;
        end else begin
          if (mthi_en) hi_d = a;
          if (mtlo_en) lo_d = a;
        end
      end
      CALC: begin
        part_hi_d = step_hi;
        part_lo_d = step_lo;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      FIX: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      op_q      <= MULT;
      mcand_q   <= '0;
      part_hi_q <= '0;
      part_lo_q <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      part_hi_q <= part_hi_d;
      part_lo_q <= part_lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv (WIDTH = 32): back-to-back vector table
// plus directed MT-write, priority and mid-operation reset sequences.
module tb_hilo_muldiv;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset_n;
  logic         start;
  md_op_t       op;
  logic [W-1:0] a, b;
  logic         mthi_en, mtlo_en;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi_en (mthi_en),
    .mtlo_en (mtlo_en),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    md_op_t       op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Assert start for one edge; returns just after the accepting edge.
  task automatic launch(input md_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns on the falling edge where done is seen (i.e. inside the done cycle).
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) break;
      @(posedge clk);
      cycles++;
    end
  endtask

  int cyc, bcyc, done_seen;

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4]  = '{DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[10] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = MULT;
    a       = '0;
    b       = '0;
    mthi_en = 1'b0;
    mtlo_en = 1'b0;

    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // MTHI alone, then MTHI+MTLO together, then hold with no enables.
    @(negedge clk);
    a = 32'hDEAD0000; mthi_en = 1'b1;
    @(posedge clk);
    #1 mthi_en = 1'b0;
    check("mthi hi", 64'(hi), 64'hDEAD0000);
    check("mthi lo untouched", 64'(lo), 64'd0);
    @(negedge clk);
    a = 32'h11112222; mthi_en = 1'b1; mtlo_en = 1'b1;
    @(posedge clk);
    #1 mthi_en = 1'b0; mtlo_en = 1'b0;
    check("mthi+mtlo hi", 64'(hi), 64'h11112222);
    check("mthi+mtlo lo", 64'(lo), 64'h11112222);
    @(negedge clk);
    a = 32'h00000999;
    @(posedge clk);
    #1 check("hold hi", 64'(hi), 64'h11112222);

    // Vector table, each op started in the done cycle of the previous one.
    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc, bcyc);
      check($sformatf("vec%0d latency", i), 64'(cyc), 64'(LAT));
      check($sformatf("vec%0d busy cycles", i), 64'(bcyc), 64'(LAT));
      check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
    end

    // start and mtlo_en together: the write is dropped.
    @(negedge clk);
    a = 32'h00005555; mtlo_en = 1'b1;
    @(posedge clk);
    #1 mtlo_en = 1'b0;
    check("pre mtlo lo", 64'(lo), 64'h00005555);
    @(negedge clk);
    mtlo_en = 1'b1;
    launch(MULTU, 32'd2, 32'd3);
    mtlo_en = 1'b0;
    check("start wins lo", 64'(lo), 64'h00005555);
    check("start wins busy", 64'(busy), 64'd1);
    wait_done(cyc, bcyc);
    check("start wins latency", 64'(cyc), 64'(LAT));
    check("start wins result lo", 64'(lo), 64'd6);
    check("start wins result hi", 64'(hi), 64'd0);

    // MT writes and a new start while busy are ignored.
    launch(MULTU, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    a = 32'hAAAA5555; b = 32'd1; op = DIVU;
    mthi_en = 1'b1; mtlo_en = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 mthi_en = 1'b0; mtlo_en = 1'b0; start = 1'b0;
    check("busy mtlo lo", 64'(lo), 64'd6);
    check("busy mthi hi", 64'(hi), 64'd0);
    wait_done(cyc, bcyc);
    check("busy op lo", 64'(lo), 64'd81);
    check("busy op hi", 64'(hi), 64'd0);

    // Load nonzero HI/LO, then reset in the middle of a MULT.
    @(negedge clk);
    a = 32'h0BADF00D; mthi_en = 1'b1; mtlo_en = 1'b1;
    @(posedge clk);
    #1 mthi_en = 1'b0; mtlo_en = 1'b0;
    @(negedge clk);
    launch(MULT, 32'h00012345, 32'h00000003);
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hi",   64'(hi),   64'd0);
    check("midreset lo",   64'(lo),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no done after reset", 64'(done_seen), 64'd0);

    launch(MULTU, 32'd6, 32'd7);
    wait_done(cyc, bcyc);
    check("post reset latency", 64'(cyc), 64'(LAT));
    check("post reset lo", 64'(lo), 64'd42);
    check("post reset hi", 64'(hi), 64'd0);
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
